// File: rtl/unaligned_store_ram_if.sv
// Store-request bus between the MEM stage and the unaligned store RAM.
// The master issues byte-addressed stores; the slave returns ready and the
// one-cycle completion/error pulses.
interface unaligned_store_ram_if #(
   parameter int WORD = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [WORD-1:0] req_addr;
   logic [1:0]      req_size;
   logic [WORD-1:0] req_data;
   logic            wr_done;
   logic            wr_err;

   modport master (
      output req_valid, req_addr, req_size, req_data,
      input  req_ready, wr_done, wr_err
   );

   modport slave (
      input  req_valid, req_addr, req_size, req_data,
      output req_ready, wr_done, wr_err
   );
endinterface

// File: rtl/unaligned_store_ram.sv
// Big-endian word RAM accepting byte/half/word stores at any byte address.
// A store that crosses a word boundary is committed over two cycles: the
// leading bytes go to word w on the accepting edge and the trailing bytes to
// word w+1 (wrapping) on the following edge, with req_ready low in between.
module unaligned_store_ram #(
   parameter int WORD  = 32,
   parameter int BYTE  = 8,
   parameter int DEPTH = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   unaligned_store_ram_if.slave bus,
   input  logic [WORD-1:0]      i_rd_addr,
   output logic [WORD-1:0]      o_rd_data
);
   localparam int NB = WORD / BYTE;
   localparam int KW = $clog2(NB);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [WORD-1:0] r_mem [DEPTH];
   logic [WORD-1:0] r_sp_data;
   logic [NB-1:0]   r_sp_be;
   logic [AW-1:0]   r_sp_idx;
   logic            r_wr_done;
   logic            r_wr_err;

   logic [KW-1:0]     w_k;
   logic [AW-1:0]     w_widx;
   logic [WORD-1:0]   w_lj;
   logic [NB-1:0]     w_lj_be;
   logic [2*WORD-1:0] w_wide;
   logic [2*NB-1:0]   w_wide_be;
   logic              w_accept;
   logic              w_illegal;
   logic              w_split;
   logic              w_we;
   logic [AW-1:0]     w_we_idx;
   logic [WORD-1:0]   w_we_data;
   logic [NB-1:0]     w_we_be;
   logic              w_done_nxt;
   logic              w_err_nxt;
   logic              w_sp_load;
   logic              w_unused;

   assign w_k       = bus.req_addr[KW-1:0];
   assign w_widx    = bus.req_addr[AW+KW-1:KW];
   assign w_accept  = bus.req_valid && (r_state == IDLE);
   assign w_illegal = (bus.req_size == 2'b11);

   // Left-justify the store data and its byte mask so the MS byte sits in lane 0.
   always_comb begin
      w_lj    = {WORD{1'b0}};
      w_lj_be = {NB{1'b0}};
      case (bus.req_size)
         2'b00: begin
            w_lj    = {bus.req_data[BYTE-1:0], {(WORD-BYTE){1'b0}}};
            w_lj_be = {1'b1, {(NB-1){1'b0}}};
         end
         2'b01: begin
            w_lj    = {bus.req_data[2*BYTE-1:0], {(WORD-2*BYTE){1'b0}}};
            w_lj_be = {2'b11, {(NB-2){1'b0}}};
         end
         2'b10: begin
            w_lj    = bus.req_data;
            w_lj_be = {NB{1'b1}};
         end
         default: begin
            w_lj    = {WORD{1'b0}};
            w_lj_be = {NB{1'b0}};
         end
      endcase
   end

   // Upper half of the double-word window lands in word w, lower half in w+1.
   assign w_wide    = {w_lj, {WORD{1'b0}}} >> (BYTE * int'(w_k));
   assign w_wide_be = {w_lj_be, {NB{1'b0}}} >> w_k;
   assign w_split   = |w_wide_be[NB-1:0];

   // Next-state and write-port selection; SPLIT replays the latched tail.
   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_we_idx    = w_widx;
      w_we_data   = w_wide[2*WORD-1:WORD];
      w_we_be     = w_wide_be[2*NB-1:NB];
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_sp_load   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_illegal) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_we = 1'b1;
                  if (w_split) begin
                     w_sp_load   = 1'b1;
                     w_state_nxt = SPLIT;
                  end else begin
                     w_done_nxt = 1'b1;
                  end
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SPLIT: begin
            w_we        = 1'b1;
            w_we_idx    = r_sp_idx;
            w_we_data   = r_sp_data;
            w_we_be     = r_sp_be;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Hold the trailing bytes and next word index of a boundary-crossing store.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sp_data <= {WORD{1'b0}};
         r_sp_be   <= {NB{1'b0}};
         r_sp_idx  <= {AW{1'b0}};
      end else if (w_sp_load) begin
         r_sp_data <= w_wide[WORD-1:0];
         r_sp_be   <= w_wide_be[NB-1:0];
         r_sp_idx  <= w_widx + AW'(1);
      end
   end

   // Registered single-cycle completion and error pulses.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_done <= 1'b0;
         r_wr_err  <= 1'b0;
      end else begin
         r_wr_done <= w_done_nxt;
         r_wr_err  <= w_err_nxt;
      end
   end

   // Memory array with per-byte write enables; cleared by reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WORD{1'b0}};
         end
      end else if (w_we) begin
         for (int b = 0; b < NB; b++) begin
            if (w_we_be[b]) begin
               r_mem[w_we_idx][b*BYTE +: BYTE] <= w_we_data[b*BYTE +: BYTE];
            end
         end
      end
   end

   assign bus.req_ready = (r_state == IDLE);
   assign bus.wr_done   = r_wr_done;
   assign bus.wr_err    = r_wr_err;
   assign o_rd_data     = r_mem[i_rd_addr[AW+KW-1:KW]];

   // Address bits above the array and the read byte offset are don't-care.
   assign w_unused = &{1'b0, bus.req_addr[WORD-1:AW+KW],
                       i_rd_addr[WORD-1:AW+KW], i_rd_addr[KW-1:0]};
endmodule

// File: tb/tb_unaligned_store_ram.sv
// Directed testbench for unaligned_store_ram: aligned, sub-word, split,
// wrapping, illegal-size, back-to-back and reset-during-split stores.
module tb_unaligned_store_ram;
   localparam int WORD  = 32;
   localparam int DEPTH = 64;

   logic            clk;
   logic            rst;
   logic [WORD-1:0] rd_addr;
   logic [WORD-1:0] rd_data;
   logic [WORD-1:0] got;
   int              vectors;
   int              miscompares;

   unaligned_store_ram_if #(.WORD(WORD)) bus ();

   unaligned_store_ram #(.WORD(WORD), .BYTE(8), .DEPTH(DEPTH)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .bus       (bus.slave),
      .i_rd_addr (rd_addr),
      .o_rd_data (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic read_word(input logic [WORD-1:0] a, output logic [WORD-1:0] d);
      rd_addr = a;
      #1;
      d = rd_data;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Present a request at the negedge; it is taken on the following posedge.
   task automatic drive_req(input logic [WORD-1:0] a, input logic [1:0] sz,
                            input logic [WORD-1:0] d);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_size  = sz;
      bus.req_data  = d;
   endtask

   task automatic drop_req();
      bus.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      vectors++;
      if (bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b want 1", bus.req_ready);
      end
      vectors++;
      if (bus.wr_done !== 1'b0 || bus.wr_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pulses: done=%b err=%b want 0 0", bus.wr_done, bus.wr_err);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      read_word(32'h0000_0000, got);
      vectors++;
      if (got !== 32'h0000_0000) begin
         miscompares++;
         $display("FAIL reset_mem0: got %h want 00000000", got);
      end
   endtask

   task automatic test_aligned_word();
      drive_req(32'h0000_0000, 2'b10, 32'hDEAD_BEEF);
      #1;
      vectors++;
      if (bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL word_ready: got %b want 1", bus.req_ready);
      end
      @(posedge clk);
      #1;
      drop_req();
      @(negedge clk);
      read_word(32'h0000_0000, got);
      vectors++;
      if (got !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL word_data: got %h want deadbeef", got);
      end
      vectors++;
      if (bus.wr_done !== 1'b1) begin
         miscompares++;
         $display("FAIL word_done: got %b want 1", bus.wr_done);
      end
      @(negedge clk);
      vectors++;
      if (bus.wr_done !== 1'b0) begin
         miscompares++;
         $display("FAIL word_done_drop: got %b want 0", bus.wr_done);
      end
   endtask

   task automatic test_subword();
      drive_req(32'h0000_0005, 2'b00, 32'h0000_00AA);
      @(posedge clk);
      #1;
      drop_req();
      @(negedge clk);
      read_word(32'h0000_0004, got);
      vectors++;
      if (got !== 32'h00AA_0000) begin
         miscompares++;
         $display("FAIL byte_lane: got %h want 00aa0000", got);
      end
      drive_req(32'h0000_0006, 2'b01, 32'hFFFF_1234);
      @(posedge clk);
      #1;
      drop_req();
      @(negedge clk);
      read_word(32'h0000_0004, got);
      vectors++;
      if (got !== 32'h00AA_1234) begin
         miscompares++;
         $display("FAIL half_merge: got %h want 00aa1234", got);
      end
   endtask

   task automatic test_split();
      do_reset();
      drive_req(32'h0000_0003, 2'b10, 32'h1122_3344);
      @(posedge clk);
      #1;
      drop_req();
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL split_ready_low: got %b want 0", bus.req_ready);
      end
      vectors++;
      if (bus.wr_done !== 1'b0) begin
         miscompares++;
         $display("FAIL split_early_done: got %b want 0", bus.wr_done);
      end
      read_word(32'h0000_0000, got);
      vectors++;
      if (got !== 32'h0000_0011) begin
         miscompares++;
         $display("FAIL split_first: got %h want 00000011", got);
      end
      @(negedge clk);
      read_word(32'h0000_0004, got);
      vectors++;
      if (got !== 32'h2233_4400) begin
         miscompares++;
         $display("FAIL split_second: got %h want 22334400", got);
      end
      vectors++;
      if (bus.wr_done !== 1'b1 || bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL split_done: done=%b ready=%b want 1 1", bus.wr_done, bus.req_ready);
      end
      @(negedge clk);
      vectors++;
      if (bus.wr_done !== 1'b0) begin
         miscompares++;
         $display("FAIL split_done_drop: got %b want 0", bus.wr_done);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      drive_req(DEPTH * 4 - 1, 2'b01, 32'h0000_CAFE);
      @(posedge clk);
      #1;
      drop_req();
      repeat (2) @(negedge clk);
      read_word(DEPTH * 4 - 4, got);
      vectors++;
      if (got !== 32'h0000_00CA) begin
         miscompares++;
         $display("FAIL wrap_last: got %h want 000000ca", got);
      end
      read_word(32'h0000_0000, got);
      vectors++;
      if (got !== 32'hFE00_0000) begin
         miscompares++;
         $display("FAIL wrap_first: got %h want fe000000", got);
      end
   endtask

   task automatic test_illegal();
      drive_req(32'h0000_0008, 2'b10, 32'h5566_7788);
      @(posedge clk);
      #1;
      drop_req();
      @(negedge clk);
      drive_req(32'h0000_0008, 2'b11, 32'h0102_0304);
      @(posedge clk);
      #1;
      drop_req();
      @(negedge clk);
      vectors++;
      if (bus.wr_err !== 1'b1 || bus.wr_done !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_pulse: err=%b done=%b want 1 0", bus.wr_err, bus.wr_done);
      end
      read_word(32'h0000_0008, got);
      vectors++;
      if (got !== 32'h5566_7788) begin
         miscompares++;
         $display("FAIL illegal_nowrite: got %h want 55667788", got);
      end
      @(negedge clk);
      vectors++;
      if (bus.wr_err !== 1'b0 || bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL illegal_drop: err=%b ready=%b want 0 1", bus.wr_err, bus.req_ready);
      end
   endtask

   task automatic test_back_to_back();
      drive_req(32'h0000_0010, 2'b00, 32'h0000_0011);
      @(posedge clk);
      #1;
      drive_req(32'h0000_0013, 2'b00, 32'h0000_0022);
      @(negedge clk);
      vectors++;
      if (bus.wr_done !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_done1: got %b want 1", bus.wr_done);
      end
      @(posedge clk);
      #1;
      drop_req();
      @(negedge clk);
      vectors++;
      if (bus.wr_done !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_done2: got %b want 1", bus.wr_done);
      end
      read_word(32'h0000_0010, got);
      vectors++;
      if (got !== 32'h1100_0022) begin
         miscompares++;
         $display("FAIL b2b_data: got %h want 11000022", got);
      end
   endtask

   task automatic test_reset_in_split();
      drive_req(32'h0000_0003, 2'b10, 32'h1122_3344);
      @(posedge clk);
      #1;
      drop_req();
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if (bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rstsplit_ready: got %b want 1", bus.req_ready);
      end
      read_word(32'h0000_0000, got);
      vectors++;
      if (got !== 32'h0000_0000) begin
         miscompares++;
         $display("FAIL rstsplit_mem0: got %h want 00000000", got);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.wr_done !== 1'b0) begin
         miscompares++;
         $display("FAIL rstsplit_done: got %b want 0", bus.wr_done);
      end
      read_word(32'h0000_0004, got);
      vectors++;
      if (got !== 32'h0000_0000) begin
         miscompares++;
         $display("FAIL rstsplit_mem1: got %h want 00000000", got);
      end
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b1;
      rd_addr       = 32'h0000_0000;
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'h0000_0000;
      bus.req_size  = 2'b00;
      bus.req_data  = 32'h0000_0000;
      test_reset();
      test_aligned_word();
      test_subword();
      test_split();
      test_wrap();
      test_illegal();
      test_back_to_back();
      test_reset_in_split();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
